// File: rtl/seven_seg_pkg.sv
// Shared segment patterns and scanner state encoding for the seven-segment display path.
// Patterns are a..g with a in bit 6, active-high.
package seven_seg_pkg;

   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1110011;
   localparam logic [6:0] SEG_A     = 7'b1110111;
   localparam logic [6:0] SEG_B     = 7'b0011111;
   localparam logic [6:0] SEG_C     = 7'b1001110;
   localparam logic [6:0] SEG_D     = 7'b0111101;
   localparam logic [6:0] SEG_E     = 7'b1001111;
   localparam logic [6:0] SEG_F     = 7'b1000111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GAP  = 2'd1,
      SHOW = 2'd2
   } state_e;

endpackage

// File: rtl/hex_to_seven_seg.sv
// Combinational hex nibble to seven-segment encoder; the exact inverse of the
// segment-to-value decoder used elsewhere in the datapath.
module hex_to_seven_seg
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   always_comb begin
      case (nibble_i)
         4'h0:    seg_o = SEG_0;
         4'h1:    seg_o = SEG_1;
         4'h2:    seg_o = SEG_2;
         4'h3:    seg_o = SEG_3;
         4'h4:    seg_o = SEG_4;
         4'h5:    seg_o = SEG_5;
         4'h6:    seg_o = SEG_6;
         4'h7:    seg_o = SEG_7;
         4'h8:    seg_o = SEG_8;
         4'h9:    seg_o = SEG_9;
         4'hA:    seg_o = SEG_A;
         4'hB:    seg_o = SEG_B;
         4'hC:    seg_o = SEG_C;
         4'hD:    seg_o = SEG_D;
         4'hE:    seg_o = SEG_E;
         default: seg_o = SEG_F;
      endcase
   end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed seven-segment scanner: round-robin digit slots with a blanking
// gap, frame-synchronous commit of loaded values and optional leading-zero blanking.
module seven_segment_scanner
   import seven_seg_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 1000,
   parameter int GAP_CYCLES  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic                  lz_blank,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     dig_en,
   output logic                  frame_done
);

   localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CW = $clog2(REFRESH_DIV);
   localparam logic [DW-1:0] LAST_DIGIT = DW'(DIGITS - 1);
   localparam logic [CW-1:0] LAST_CNT   = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] GAP_END    = CW'(GAP_CYCLES - 1);

   if (DIGITS < 1) begin : g_bad_digits
      $error("seven_segment_scanner: DIGITS must be >= 1");
   end
   if (REFRESH_DIV < 2) begin : g_bad_div
      $error("seven_segment_scanner: REFRESH_DIV must be >= 2");
   end
   if (GAP_CYCLES < 1 || GAP_CYCLES >= REFRESH_DIV) begin : g_bad_gap
      $error("seven_segment_scanner: GAP_CYCLES must be in 1..REFRESH_DIV-1");
   end

   state_e                state_q, state_d;
   logic [DW-1:0]         digit_q, digit_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [4*DIGITS-1:0]   shadow_q, shadow_d;
   logic [4*DIGITS-1:0]   active_q, active_d;
   logic                  pending_q, pending_d;
   logic [6:0]            seg_q, seg_d;
   logic [DIGITS-1:0]     dig_en_q, dig_en_d;
   logic                  frame_done_q, frame_done_d;

   logic                  frame_end;
   logic [3:0]            nibble;
   logic [6:0]            hex_seg;
   logic                  upper_nonzero;
   logic                  blank;

   // Slot sequencing: enable low always wins and parks the scanner in IDLE.
   always_comb begin
      // NOTE: every combinational output is given a default first so no latch is inferred.
      state_d   = state_q;
      digit_d   = digit_q;
      cnt_d     = cnt_q;
      frame_end = 1'b0;
      if (!enable) begin
         state_d = IDLE;
         digit_d = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = GAP;
               digit_d = '0;
               cnt_d   = '0;
            end
            GAP: begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == GAP_END) state_d = SHOW;
            end
            SHOW: begin
               if (cnt_q == LAST_CNT) begin
                  cnt_d     = '0;
                  state_d   = GAP;
                  frame_end = (digit_q == LAST_DIGIT);
                  digit_d   = frame_end ? '0 : digit_q + DW'(1);
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: begin
               state_d = IDLE;
               digit_d = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      shadow_d  = shadow_q;
      active_d  = active_q;
      pending_d = pending_q;
      if (load) begin
         shadow_d  = value;
         pending_d = 1'b1;
      end
      // A load landing on the commit cycle bypasses the shadow so it is not lost.
      if (frame_end) begin
         if (load)           active_d = value;
         else if (pending_q) active_d = shadow_q;
         pending_d = 1'b0;
      end
   end

   always_comb begin
      nibble        = 4'h0;
      upper_nonzero = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (digit_q == DW'(i)) nibble = active_q[4*i +: 4];
         if (i >= int'(digit_q) && active_q[4*i +: 4] != 4'h0) upper_nonzero = 1'b1;
      end
      blank = lz_blank && (digit_q != '0) && !upper_nonzero;
   end

   hex_to_seven_seg u_hex_to_seven_seg (
      .nibble_i (nibble),
      .seg_o    (hex_seg)
   );

   always_comb begin
      seg_d        = SEG_BLANK;
      dig_en_d     = '0;
      frame_done_d = frame_end;
      if (enable && state_q == SHOW) begin
         seg_d = blank ? SEG_BLANK : hex_seg;
         for (int i = 0; i < DIGITS; i++) dig_en_d[i] = (digit_q == DW'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         digit_q      <= '0;
         cnt_q        <= '0;
         // NOTE: the value registers are reset too, so the display comes up blank and a reset drops the old value.
         shadow_q     <= '0;
         active_q     <= '0;
         pending_q    <= 1'b0;
         seg_q        <= SEG_BLANK;
         dig_en_q     <= '0;
         frame_done_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values.
         state_q      <= state_d;
         digit_q      <= digit_d;
         cnt_q        <= cnt_d;
         shadow_q     <= shadow_d;
         active_q     <= active_d;
         pending_q    <= pending_d;
         seg_q        <= seg_d;
         dig_en_q     <= dig_en_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign seg        = seg_q;
   assign dig_en     = dig_en_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner: directed scenarios followed by
// random stimulus, all compared every cycle against a frame-position reference model.
module tb_seven_segment_scanner;

   localparam int DIGITS      = 4;
   localparam int REFRESH_DIV = 8;
   localparam int GAP_CYCLES  = 2;
   localparam int FRAME       = DIGITS * REFRESH_DIV;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        load;
   logic [15:0] value;
   logic        lz_blank;
   logic [6:0]  seg;
   logic [3:0]  dig_en;
   logic        frame_done;

   always #5 clk = ~clk;

   seven_segment_scanner #(
      .DIGITS      (DIGITS),
      .REFRESH_DIV (REFRESH_DIV),
      .GAP_CYCLES  (GAP_CYCLES)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .load       (load),
      .value      (value),
      .lz_blank   (lz_blank),
      .seg        (seg),
      .dig_en     (dig_en),
      .frame_done (frame_done)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [6:0] seg_table [16];

   // Reference model: position within the frame since scanning started.
   bit          m_run;
   int          m_pos;
   logic [15:0] m_shadow, m_active;
   bit          m_pending;
   logic [6:0]  e_seg;
   logic [3:0]  e_dig;
   logic        e_fd;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_pos = 0; m_shadow = '0; m_active = '0; m_pending = 0;
      e_seg = '0; e_dig = '0; e_fd = 1'b0;
   endtask

   task automatic model_edge();
      int slot, off;
      logic [15:0] upper;
      e_seg = '0; e_dig = '0; e_fd = 1'b0;
      if (!rst_n) begin
         model_reset();
         return;
      end
      if (enable && m_run) begin
         slot = m_pos / REFRESH_DIV;
         off  = m_pos % REFRESH_DIV;
         if (off >= GAP_CYCLES) begin
            e_dig = 4'(1 << slot);
            upper = m_active >> (4 * slot);
            if (lz_blank && slot > 0 && upper == 16'h0) e_seg = '0;
            else e_seg = seg_table[int'(upper & 16'hF)];
         end
         e_fd = (m_pos == FRAME - 1);
      end
      if (enable && m_run && m_pos == FRAME - 1) begin
         if (load) begin
            m_active = value;
            m_shadow = value;
         end else if (m_pending) begin
            m_active = m_shadow;
         end
         m_pending = 0;
      end else if (load) begin
         m_shadow  = value;
         m_pending = 1;
      end
      if (!enable) begin
         m_run = 0; m_pos = 0;
      end else if (!m_run) begin
         m_run = 1; m_pos = 0;
      end else begin
         m_pos = (m_pos + 1) % FRAME;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("seg", 32'(seg), 32'(e_seg));
      check("dig_en", 32'(dig_en), 32'(e_dig));
      check("frame_done", 32'(frame_done), 32'(e_fd));
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic pulse_load(input logic [15:0] v);
      load = 1'b1; value = v;
      step();
      load = 1'b0;
   endtask

   task automatic wait_pos(input string tag, input int pos);
      int k = 0;
      while (!(m_run && m_pos == pos) && k < 4 * FRAME) begin
         step();
         k++;
      end
      check(tag, 32'(k < 4 * FRAME), 32'd1);
   endtask

   initial begin
      seg_table[0]  = 7'b1111110; seg_table[1]  = 7'b0110000;
      seg_table[2]  = 7'b1101101; seg_table[3]  = 7'b1111001;
      seg_table[4]  = 7'b0110011; seg_table[5]  = 7'b1011011;
      seg_table[6]  = 7'b1011111; seg_table[7]  = 7'b1110000;
      seg_table[8]  = 7'b1111111; seg_table[9]  = 7'b1110011;
      seg_table[10] = 7'b1110111; seg_table[11] = 7'b0011111;
      seg_table[12] = 7'b1001110; seg_table[13] = 7'b0111101;
      seg_table[14] = 7'b1001111; seg_table[15] = 7'b1000111;

      rst_n = 1'b0; enable = 1'b0; load = 1'b0; value = '0; lz_blank = 1'b0;
      model_reset();
      #1;
      check("rst_seg", 32'(seg), 32'd0);
      check("rst_dig_en", 32'(dig_en), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      run(2);
      rst_n = 1'b1;
      run(2);

      // First slot timing after enable: 3 blank cycles, then digit 0 for 6.
      enable = 1'b1;
      run(3);
      check("first_gap", 32'(dig_en), 32'd0);
      step();
      check("first_show", 32'(dig_en), 32'b0001);
      run(5);
      check("first_show_end", 32'(dig_en), 32'b0001);
      step();
      check("second_gap", 32'(dig_en), 32'd0);

      pulse_load(16'h1A2F);
      run(2 * FRAME);

      pulse_load(16'h1111);
      run(5);
      pulse_load(16'h2222);
      run(2 * FRAME);

      // Load on the exact commit cycle.
      wait_pos("beef_sync", FRAME - 1);
      pulse_load(16'hBEEF);
      run(2 * FRAME);

      lz_blank = 1'b1;
      pulse_load(16'h0050);
      run(2 * FRAME);
      pulse_load(16'h0000);
      run(2 * FRAME);
      lz_blank = 1'b0;
      pulse_load(16'h3C07);
      run(FRAME + 4);

      // Enable dropped mid-slot, then restart from digit 0.
      wait_pos("drop_sync", 13);
      enable = 1'b0;
      step();
      check("drop_dig_en", 32'(dig_en), 32'd0);
      run(3);
      enable = 1'b1;
      run(FRAME + 8);

      // Asynchronous reset mid-frame while a digit is lit.
      wait_pos("rst_sync", 20);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_seg", 32'(seg), 32'd0);
      check("async_rst_dig_en", 32'(dig_en), 32'd0);
      check("async_rst_frame_done", 32'(frame_done), 32'd0);
      model_reset();
      step();
      rst_n = 1'b1;
      run(FRAME + 4);

      for (int i = 0; i < 2500; i++) begin
         enable = ($urandom_range(0, 99) > 2);
         load   = ($urandom_range(0, 9) == 0);
         value  = 16'($urandom) >> (4 * $urandom_range(0, 4));
         if ($urandom_range(0, 49) == 0) lz_blank = ~lz_blank;
         step();
      end
      load = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

- Time-multiplexed controller for a multi-digit seven-segment display whose digits share one set of segment lines.
- Scans the digits in a fixed round-robin, driving one digit enable and that digit's segment pattern at a time, with a blanking gap before each digit to prevent ghosting.
- New display values are accepted on a load strobe and committed only at a frame boundary, so a frame never mixes old and new digits.
- Sits between the numeric datapath and the display pins; segment encoding is the exact inverse of the team's segment-to-value decoder.

## Interface
- DIGITS, 4, number of multiplexed digits (≥1)
- REFRESH_DIV, 1000, clock cycles per digit slot (≥2)
- GAP_CYCLES, 2, blanked cycles at the start of each slot (1 ≤ GAP_CYCLES < REFRESH_DIV)
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- enable  in  1  scanning on when high
- load  in  1  single-cycle strobe; capture `value`
- value  in  4*DIGITS  hex nibbles; `value[3:0]` is digit 0 (rightmost)
- lz_blank  in  1  suppress leading zeros when high
- seg  out  7  segments a..g, a = bit 6, active-high; `0` → 7'b1111110
- dig_en  out  DIGITS  one-hot-or-zero digit enable, active-high
- frame_done  out  1  one-cycle pulse at end of each complete frame

## Operation
- Registers:
  - `shadow` (4*DIGITS): last loaded value.
  - `active` (4*DIGITS): value being displayed.
  - `pending`: 1 when `shadow` has not yet been committed.
  - `digit`: index, 0..DIGITS-1.
  - `cnt`: slot counter, 0..REFRESH_DIV-1.
  - `state`.
- FSM states:
  - IDLE: enable=0; all outputs 0.
  - GAP: cnt < GAP_CYCLES.
  - SHOW: cnt ≥ GAP_CYCLES.
- IDLE→GAP when enable is sampled 1; digit=0, cnt=0.
- GAP→SHOW when cnt = GAP_CYCLES-1.
- SHOW at cnt = REFRESH_DIV-1: cnt→0, digit→digit+1, state→GAP. Digit wraps DIGITS-1→0.
- enable sampled 0 in any state → IDLE next cycle; digit and cnt cleared. active, shadow and pending are retained.
- Encoding (hex → seg, a..g):
  - 0 1111110, 1 0110000, 2 1101101, 3 1111001
  - 4 0110011, 5 1011011, 6 1011111, 7 1110000
  - 8 1111111, 9 1110011, A 1110111, b 0011111
  - C 1001110, d 0111101, E 1001111, F 1000111
- Leading-zero blanking: when lz_blank=1, digit d shows seg=0 (dig_en still asserted) if d>0 and all nibbles d..DIGITS-1 of `active` are 0. Digit 0 is never blanked.
- Load: `load`=1 → shadow←value, pending←1. Loads while pending overwrite; the last one wins.
- Commit (frame end): SHOW, digit=DIGITS-1, cnt=REFRESH_DIV-1.
  - If pending: active←shadow, pending←0.
  - If load coincides with commit: the incoming `value` is committed directly and pending ends 0.
- frame_done pulses at every frame end, whether or not a commit occurs.

## Timing
- Reset values: seg=0, dig_en=0, frame_done=0, active=0, shadow=0, pending=0, state=IDLE, digit=0, cnt=0.
- seg, dig_en and frame_done are registered decodes of (state, digit, cnt, active); they lag the internal state by one cycle.
- Enable sampled high at edge E:
  - dig_en[0] first asserts GAP_CYCLES+1 cycles after E.
  - dig_en[0] stays high for REFRESH_DIV-GAP_CYCLES cycles.
- Frame period: DIGITS*REFRESH_DIV cycles.
- Load-to-display latency: at most one full frame plus one cycle.
- dig_en and seg change only on GAP/SHOW edges, so seg is stable whenever any dig_en bit is high. During GAP, seg=0 and dig_en=0.
- rst_n asserted mid-frame clears everything asynchronously; the previously displayed value is lost.

## Structure
- Package `seven_seg_pkg`:
  - SEG_0..SEG_F and SEG_BLANK constants (7 bits).
  - State enum {IDLE, GAP, SHOW}.
- Sub-module `hex_to_seven_seg`: combinational, 4-bit nibble → 7-bit seg via the package constants. Instantiated once, fed by a nibble mux on `digit`.
- Elaboration-time assertions on the parameter ranges.

## Test plan
All scenarios use DIGITS=4, REFRESH_DIV=8, GAP_CYCLES=2.
- Reset, then enable=1 → dig_en sequence 0000×3, 0001×6, 0000×2, 0010×6, …; frame_done pulses every 32 cycles.
- Load value=16'h1A2F before the first frame end → next frame shows seg 0110000 / 1110111 / 1101101 / 1000111 on digits 3/2/1/0.
- Load 16'h1111 then 16'h2222 within one frame → only 2222 is committed; no frame mixes old and new digits.
- load coincident with the frame-end cycle, value=16'hBEEF → BEEF displayed from the next frame; pending=0.
- lz_blank=1, value=16'h0050 → digits 3 and 2 have seg=0 with dig_en pulsing; digit 1 shows 1011011, digit 0 shows 1111110. value=0 → only digit 0 lit, showing 0.
- enable dropped mid-slot → outputs 0 from the next cycle. Re-enable → restarts at digit 0 with the prior active value. rst_n pulsed mid-frame → all outputs and registers 0 immediately.
